// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FP16 width macros, normalize/round FSM states and FP16 encoding constants.
// Width macros FP16_FRACW / FP16_EXPW default here unless already defined by the build.
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif
`ifndef FP16_EXPW
`define FP16_EXPW 5
`endif

package fpu_pkg;
    typedef enum logic [1:0] {
        NORM_WAIT,
        NORM_SHIFT,
        NORM_ROUND,
        NORM_DONE
    } normState_t;

    localparam int unsigned BIAS    = 15;
    localparam logic [4:0]  EXP_INF = 5'h1F;
endpackage

// File: rtl/fp16_norm_round_fsm.sv
// Control FSM for fp16_norm_round: state register, datapath enables decoded from state, registered done.
module fp16NormRoundFSM
    import fpu_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic i_start,
    input  logic i_in_zero,
    input  logic i_msb,
    input  logic i_norm,
    output logic o_load,
    output logic o_shift_r,
    output logic o_shift_l,
    output logic o_round,
    output logic o_done
);
    normState_t r_state;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        o_load    = i_start && (r_state == NORM_WAIT || r_state == NORM_DONE);
        o_shift_r = (r_state == NORM_SHIFT) && i_msb;
        o_shift_l = (r_state == NORM_SHIFT) && !i_msb && !i_norm;
        o_round   = (r_state == NORM_ROUND);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= NORM_WAIT;
            o_done  <= 1'b0;
        end else begin
            // A restart from DONE drops done on the capturing edge.
            o_done <= (r_state == NORM_DONE) && !i_start;
            case (r_state)
                NORM_WAIT, NORM_DONE: if (i_start) r_state <= i_in_zero ? NORM_DONE : NORM_SHIFT;
                NORM_SHIFT:           if (!i_msb && i_norm) r_state <= NORM_ROUND;
                NORM_ROUND:           r_state <= NORM_DONE;
                default:              r_state <= NORM_WAIT;
            endcase
        end
    end
endmodule

// File: rtl/fp16_norm_round.sv
// Post-FMAD normalize (one bit per cycle) and round stage packing an FP16 fraction/exponent with flags.
// Define FPU_NORM_RNE_EN for round-to-nearest-even; otherwise the result is truncated toward zero.
module fp16_norm_round
    import fpu_pkg::*;
#(
    parameter int FRAC_WIDTH = `FP16_FRACW,
    parameter int EXP_WIDTH  = `FP16_EXPW,
    parameter int IN_WIDTH   = 2*(FRAC_WIDTH+1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   normIn,
    input  logic [EXP_WIDTH+1:0]  expIn,
    input  logic                  signIn,
    output logic [FRAC_WIDTH-1:0] fracOut,
    output logic [EXP_WIDTH-1:0]  expOut,
    output logic                  signOut,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  done
);
    localparam logic signed [EXP_WIDTH+1:0] EXP_ONE  = (EXP_WIDTH+2)'(1);
    localparam logic signed [EXP_WIDTH+1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_WIDTH+1:0] EXP_MAX  = (EXP_WIDTH+2)'((1 << EXP_WIDTH) - 1);

    logic [IN_WIDTH-1:0]         r_mant;
    logic signed [EXP_WIDTH+1:0] r_exp;
    logic                        r_sign;

    logic                        w_load, w_shift_r, w_shift_l, w_round, w_in_zero;
    logic [FRAC_WIDTH-1:0]       w_frac_rnd;
    logic signed [EXP_WIDTH+1:0] w_exp_rnd;
    logic                        w_ovf, w_unf;
`ifdef FPU_NORM_RNE_EN
    logic                        r_sticky;
    logic                        w_guard, w_rs, w_inc;
    logic [FRAC_WIDTH:0]         w_frac_sum;
`endif

    assign w_in_zero = (normIn == '0);

    fp16NormRoundFSM u_fsm (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_start   (start),
        .i_in_zero (w_in_zero),
        .i_msb     (r_mant[IN_WIDTH-1]),
        .i_norm    (r_mant[IN_WIDTH-2]),
        .o_load    (w_load),
        .o_shift_r (w_shift_r),
        .o_shift_l (w_shift_l),
        .o_round   (w_round),
        .o_done    (done)
    );

    always_comb begin
        w_frac_rnd = r_mant[IN_WIDTH-3 -: FRAC_WIDTH];
        w_exp_rnd  = r_exp;
`ifdef FPU_NORM_RNE_EN
        w_guard    = r_mant[IN_WIDTH-3-FRAC_WIDTH];
        w_rs       = (|r_mant[IN_WIDTH-4-FRAC_WIDTH:0]) | r_sticky;
        w_inc      = w_guard & (w_rs | w_frac_rnd[0]);
        w_frac_sum = {1'b0, w_frac_rnd} + (FRAC_WIDTH+1)'(w_inc);
        if (w_frac_sum[FRAC_WIDTH]) begin
            // 1.11..1 rounded up becomes 10.00..0: renormalise by bumping the exponent.
            w_frac_rnd = '0;
            w_exp_rnd  = r_exp + EXP_ONE;
        end else begin
            w_frac_rnd = w_frac_sum[FRAC_WIDTH-1:0];
        end
`endif
        w_ovf = (w_exp_rnd >= EXP_MAX);
        w_unf = !w_ovf && (w_exp_rnd <= EXP_ZERO);
    end

    // NOTE: the datapath is small and control-visible, so every register is reset, not just the FSM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mant    <= '0;
            r_exp     <= '0;
            r_sign    <= 1'b0;
            fracOut   <= '0;
            expOut    <= '0;
            signOut   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
`ifdef FPU_NORM_RNE_EN
            r_sticky  <= 1'b0;
`endif
        end else if (w_load) begin
            r_mant <= normIn;
            r_exp  <= $signed(expIn);
            r_sign <= signIn;
`ifdef FPU_NORM_RNE_EN
            r_sticky <= 1'b0;
`endif
            if (w_in_zero) begin
                fracOut   <= '0;
                expOut    <= '0;
                signOut   <= signIn;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
        end else if (w_shift_r) begin
            r_mant <= r_mant >> 1;
            r_exp  <= r_exp + EXP_ONE;
`ifdef FPU_NORM_RNE_EN
            r_sticky <= r_sticky | r_mant[0];
`endif
        end else if (w_shift_l) begin
            r_mant <= r_mant << 1;
            r_exp  <= r_exp - EXP_ONE;
        end else if (w_round) begin
            signOut   <= r_sign;
            overflow  <= w_ovf;
            underflow <= w_unf;
            fracOut   <= (w_ovf || w_unf) ? '0 : w_frac_rnd;
            expOut    <= w_ovf ? EXP_INF : (w_unf ? '0 : w_exp_rnd[EXP_WIDTH-1:0]);
        end
    end
endmodule

// File: tb/tb_fp16_norm_round.sv
// Directed-vector bench for fp16_norm_round: latency, packed result, flags, reset abort.
// Expected fractions follow FPU_NORM_RNE_EN when the bench is built with it.
module tb_fp16_norm_round;
    import fpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [21:0] normIn = '0;
    logic [6:0]  expIn = '0;
    logic        signIn = 1'b0;
    logic [9:0]  fracOut;
    logic [4:0]  expOut;
    logic        signOut, overflow, underflow, done;

    int n_checks = 0;
    int n_pass   = 0;

    fp16_norm_round dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .normIn    (normIn),
        .expIn     (expIn),
        .signIn    (signIn),
        .fracOut   (fracOut),
        .expOut    (expOut),
        .signOut   (signOut),
        .overflow  (overflow),
        .underflow (underflow),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Launch one operation, count edges until done, then compare the packed result.
    task automatic run(input string tag, input logic [21:0] n, input int e, input logic s,
                       input logic [9:0] x_frac, input logic [4:0] x_exp,
                       input logic x_ovf, input logic x_unf, input int x_lat);
        int cycles;
        @(negedge clock);
        normIn = n;
        expIn  = 7'(e);
        signIn = s;
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clock);
            #1 cycles++;
            if (done) break;
        end
        check({tag, ".latency"}, 32'(cycles), 32'(x_lat));
        check({tag, ".frac"}, 32'(fracOut), 32'(x_frac));
        check({tag, ".exp"}, 32'(expOut), 32'(x_exp));
        check({tag, ".sign"}, 32'(signOut), 32'(s));
        check({tag, ".ovf"}, 32'(overflow), 32'(x_ovf));
        check({tag, ".unf"}, 32'(underflow), 32'(x_unf));
        @(posedge clock);
        #1 check({tag, ".done_hold"}, 32'(done), 32'd1);
        check({tag, ".frac_hold"}, 32'(fracOut), 32'(x_frac));
    endtask

    initial begin
        #12;
        check("reset.done", 32'(done), 32'd0);
        check("reset.out", {fracOut, expOut, signOut, overflow, underflow}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run("t1",     22'h100000, BIAS, 1'b0, 10'h000, 5'd15, 1'b0, 1'b0, 3);
        run("t1neg",  22'h100000, BIAS, 1'b1, 10'h000, 5'd15, 1'b0, 1'b0, 3);
        run("t2",     22'h200000, BIAS, 1'b0, 10'h000, 5'd16, 1'b0, 1'b0, 4);
        run("t3",     22'h000400, 25,   1'b0, 10'h000, 5'd15, 1'b0, 1'b0, 13);
        run("deep",   22'h000001, 40,   1'b1, 10'h000, 5'd20, 1'b0, 1'b0, 23);
        run("ovf",    22'h200000, 30,   1'b0, 10'h000, 5'h1F, 1'b1, 1'b0, 4);
        run("ovf31",  22'h100000, 31,   1'b0, 10'h000, 5'h1F, 1'b1, 1'b0, 3);
        run("max30",  22'h100000, 30,   1'b0, 10'h000, 5'h1E, 1'b0, 1'b0, 3);
        run("unf",    22'h100000, 0,    1'b0, 10'h000, 5'd0,  1'b0, 1'b1, 3);
        run("zero",   22'h000000, BIAS, 1'b1, 10'h000, 5'd0,  1'b0, 1'b0, 1);
`ifdef FPU_NORM_RNE_EN
        run("t4",     22'h100600, BIAS, 1'b0, 10'h002, 5'd15, 1'b0, 1'b0, 3);
        run("carry",  22'h1FFE00, BIAS, 1'b0, 10'h000, 5'd16, 1'b0, 1'b0, 3);
        run("sticky", 22'h200401, BIAS, 1'b0, 10'h001, 5'd16, 1'b0, 1'b0, 4);
        run("tie",    22'h100200, BIAS, 1'b0, 10'h000, 5'd15, 1'b0, 1'b0, 3);
`else
        run("sticky", 22'h200401, BIAS, 1'b0, 10'h000, 5'd16, 1'b0, 1'b0, 4);
        run("tie",    22'h100200, BIAS, 1'b0, 10'h000, 5'd15, 1'b0, 1'b0, 3);
        run("carry",  22'h1FFE00, BIAS, 1'b0, 10'h3FF, 5'd15, 1'b0, 1'b0, 3);
        run("t4",     22'h100600, BIAS, 1'b0, 10'h001, 5'd15, 1'b0, 1'b0, 3);
`endif

        // Abort a long normalisation with reset; the held result must clear.
        @(negedge clock);
        normIn = 22'h000400;
        expIn  = 7'd25;
        signIn = 1'b1;
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort.done", 32'(done), 32'd0);
        check("abort.out", {fracOut, expOut, signOut, overflow, underflow}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run("after_abort", 22'h100600, 17, 1'b0,
`ifdef FPU_NORM_RNE_EN
            10'h002,
`else
            10'h001,
`endif
            5'd17, 1'b0, 1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
